// File: rtl/dot_host_driver.sv
`default_nettype none
// ============================================================================
// Module      : dot_host_driver
// Description : Host-side initiator for the 4-lane 8-bit dot-product
//               accelerator: streams operands, reads back the 18-bit result.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_host_driver #(
    parameter int SETTLE_CYCLES = 2,
    parameter int READ_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] data_vec,
    input  logic [31:0] weight_vec,
    output logic        busy,
    output logic        done,
    output logic [17:0] result,
    output logic        error,
    output logic [7:0]  bus_byte,
    output logic        bus_sel,
    output logic        bus_valid,
    output logic        rd_req,
    input  logic [9:0]  rsp_word,
    input  logic        rsp_valid
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_D = 3'd1,
        S_LOAD_W = 3'd2,
        S_SETTLE = 3'd3,
        S_READ   = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    localparam logic [7:0] c_settle_last  = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] c_timeout_last = 8'(READ_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_data;
    logic [31:0] r_weight;
    logic [8:0]  r_lo;
    logic [8:0]  r_hi;
    logic        r_lo_flag;
    logic        r_hi_flag;
    logic [17:0] r_result;
    logic        r_error;

    logic [31:0] w_src;
    logic [7:0]  w_byte;
    logic [8:0]  w_lo_val;
    logic [8:0]  w_hi_val;
    logic        w_lo_flag;
    logic        w_hi_flag;
    logic        w_both;

    // Merge this cycle's response with the halves already held so a capture
    // that completes the pair is visible to the exit decision immediately.
    assign w_lo_flag = r_lo_flag | (rsp_valid & rsp_word[9]);
    assign w_hi_flag = r_hi_flag | (rsp_valid & ~rsp_word[9]);
    assign w_lo_val  = (rsp_valid & rsp_word[9])  ? rsp_word[8:0] : r_lo;
    assign w_hi_val  = (rsp_valid & ~rsp_word[9]) ? rsp_word[8:0] : r_hi;
    assign w_both    = w_lo_flag & w_hi_flag;

    assign w_src = (r_state == S_LOAD_W) ? r_weight : r_data;

    always_comb begin
        w_byte = 8'h00;
        case (r_cnt[1:0])
            2'd0:    w_byte = w_src[31:24];
            2'd1:    w_byte = w_src[23:16];
            2'd2:    w_byte = w_src[15:8];
            default: w_byte = w_src[7:0];
        endcase
    end

    assign result = r_result;
    assign error  = r_error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        bus_valid    = 1'b0;
        bus_sel      = 1'b0;
        bus_byte     = 8'h00;
        rd_req       = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = S_LOAD_D;
                end
            end
            S_LOAD_D: begin
                bus_valid = 1'b1;
                bus_byte  = w_byte;
                if (r_cnt[1:0] == 2'd3) begin
                    w_next_state = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                bus_valid = 1'b1;
                bus_sel   = 1'b1;
                bus_byte  = w_byte;
                if (r_cnt[1:0] == 2'd3) begin
                    w_next_state = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == c_settle_last) begin
                    w_next_state = S_READ;
                end
            end
            S_READ: begin
                rd_req = 1'b1;
                if (w_both || (r_cnt == c_timeout_last)) begin
                    w_next_state = S_FIN;
                end
            end
            S_FIN: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // One shared counter: it restarts on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 8'h00;
            r_data    <= 32'h0;
            r_weight  <= 32'h0;
            r_lo      <= 9'h000;
            r_hi      <= 9'h000;
            r_lo_flag <= 1'b0;
            r_hi_flag <= 1'b0;
            r_result  <= 18'h0;
            r_error   <= 1'b0;
        end else begin
            if (w_next_state != r_state) begin
                r_cnt <= 8'h00;
            end else begin
                r_cnt <= r_cnt + 8'h01;
            end
            if ((r_state == S_IDLE) && start) begin
                r_data    <= data_vec;
                r_weight  <= weight_vec;
                r_lo_flag <= 1'b0;
                r_hi_flag <= 1'b0;
            end
            if (r_state == S_READ) begin
                r_lo      <= w_lo_val;
                r_hi      <= w_hi_val;
                r_lo_flag <= w_lo_flag;
                r_hi_flag <= w_hi_flag;
                if (w_next_state == S_FIN) begin
                    r_error  <= ~w_both;
                    r_result <= w_both ? {w_hi_val, w_lo_val} : 18'h0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dot_host_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot_host_driver
// Description : Directed self-checking bench for dot_host_driver with a
//               cycle-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_host_driver;

    localparam int S = 2;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] data_vec = 32'h0;
    logic [31:0] weight_vec = 32'h0;
    logic [9:0]  rsp_word = 10'h0;
    logic        rsp_valid = 1'b0;
    logic        busy, done, error, bus_sel, bus_valid, rd_req;
    logic [17:0] result;
    logic [7:0]  bus_byte;

    dot_host_driver #(.SETTLE_CYCLES(S), .READ_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .start(start), .data_vec(data_vec),
        .weight_vec(weight_vec), .busy(busy), .done(done), .result(result),
        .error(error), .bus_byte(bus_byte), .bus_sel(bus_sel),
        .bus_valid(bus_valid), .rd_req(rd_req), .rsp_word(rsp_word),
        .rsp_valid(rsp_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_k counts cycles since the transaction began (1 = first data byte).
    int          m_k = 0;
    bit          m_fin = 0;
    logic [31:0] m_data = 0, m_weight = 0, m_shift;
    logic [8:0]  m_lo = 0, m_hi = 0;
    bit          m_lof = 0, m_hif = 0;
    logic [17:0] m_result = 0;
    bit          m_error = 0;
    bit          e_ld, e_lw, e_rd;
    logic [7:0]  e_byte;

    task automatic model_reset();
        m_k = 0; m_fin = 0; m_lof = 0; m_hif = 0;
        m_result = 18'h0; m_error = 0;
    endtask

    always @(negedge clk) begin
        if (rst) model_reset();
        e_ld = (m_k >= 1) && (m_k <= 4);
        e_lw = (m_k >= 5) && (m_k <= 8);
        e_rd = !m_fin && (m_k > 8 + S);
        e_byte = 8'h00;
        if (e_ld) begin m_shift = m_data >> (8 * (4 - m_k)); e_byte = m_shift[7:0]; end
        if (e_lw) begin m_shift = m_weight >> (8 * (8 - m_k)); e_byte = m_shift[7:0]; end
        chk("busy", busy, m_k != 0);
        chk("done", done, m_fin);
        chk("bus_valid", bus_valid, e_ld || e_lw);
        chk("bus_sel", bus_sel, e_lw);
        chk("bus_byte", bus_byte, e_byte);
        chk("rd_req", rd_req, e_rd);
        chk("result", result, m_result);
        chk("error", error, m_error);
        if (!rst) begin
            if (m_k == 0) begin
                if (start) begin
                    m_data = data_vec; m_weight = weight_vec;
                    m_lof = 0; m_hif = 0; m_k = 1;
                end
            end else if (m_fin) begin
                m_fin = 0; m_k = 0;
            end else if (e_rd) begin
                if (rsp_valid) begin
                    if (rsp_word[9]) begin m_lo = rsp_word[8:0]; m_lof = 1; end
                    else begin m_hi = rsp_word[8:0]; m_hif = 1; end
                end
                if (m_lof && m_hif) begin
                    m_fin = 1; m_result = {m_hi, m_lo}; m_error = 0;
                end else if (m_k - (8 + S) == T) begin
                    m_fin = 1; m_result = 18'h0; m_error = 1;
                end else begin
                    m_k++;
                end
            end else begin
                m_k++;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic rsp(input logic [9:0] w);
        rsp_valid = 1'b1; rsp_word = w; tick();
        rsp_valid = 1'b0; rsp_word = 10'h0;
    endtask

    task automatic begin_txn(input logic [31:0] d, input logic [31:0] w);
        data_vec = d; weight_vec = w; start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic expect_done(input string name, input logic [17:0] res, input logic err);
        chk({name, "_done"}, done, 1'b1);
        chk({name, "_result"}, result, res);
        chk({name, "_error"}, error, err);
    endtask

    initial begin
        ticks(3);
        chk("rst_busy", busy, 1'b0);
        chk("rst_result", result, 18'h0);
        rst = 1'b0;
        tick();

        // 1: basic transaction, responses low then high
        begin_txn(32'h01020304, 32'h05060708);
        chk("t1_byte0", bus_byte, 8'h01);
        ticks(3);
        chk("t1_byte3", bus_byte, 8'h04);
        tick();
        chk("t1_wbyte0", bus_byte, 8'h05);
        chk("t1_wsel", bus_sel, 1'b1);
        ticks(6);
        chk("t1_rdreq", rd_req, 1'b1);
        rsp(10'h246);
        chk("t1_notyet", done, 1'b0);
        rsp(10'h000);
        expect_done("t1", 18'h00046, 1'b0);
        tick();

        // 2: all ones, reversed response order, operand changes mid-flight
        begin_txn(32'hFFFFFFFF, 32'hFFFFFFFF);
        data_vec = 32'h0; weight_vec = 32'h0;
        ticks(10);
        rsp(10'h1FC);
        rsp(10'h204);
        expect_done("t2", 18'h3F804, 1'b0);
        tick();

        // 3: stray response during LOAD_W, repeated low half
        begin_txn(32'h12345678, 32'h9ABCDEF0);
        ticks(5);
        rsp(10'h3FF);
        ticks(4);
        rsp(10'h201);
        rsp(10'h205);
        rsp(10'h003);
        expect_done("t3", 18'h00605, 1'b0);
        tick();

        // 4: timeout, then completion in the final timeout cycle
        begin_txn(32'hCAFEF00D, 32'h0BADBEEF);
        ticks(25);
        chk("t4_notyet", done, 1'b0);
        tick();
        expect_done("t4", 18'h0, 1'b1);
        tick();
        begin_txn(32'h11111111, 32'h22222222);
        ticks(10);
        rsp(10'h2AA);
        ticks(14);
        rsp(10'h155);
        expect_done("t4b", 18'h2AAAA, 1'b0);
        tick();

        // 5: start ignored while busy; start held through FIN
        begin_txn(32'hA1B2C3D4, 32'hE5F60718);
        ticks(5);
        start = 1'b1; tick(); start = 1'b0;
        ticks(4);
        rsp(10'h2EE);
        start = 1'b1;
        rsp(10'h011);
        expect_done("t5", 18'h022EE, 1'b0);
        ticks(2);
        start = 1'b0;
        chk("t5_restart_busy", busy, 1'b1);
        chk("t5_restart_byte", bus_byte, 8'hA1);
        ticks(10);
        rsp(10'h3FF);
        rsp(10'h1FF);
        expect_done("t5b", 18'h3FFFF, 1'b0);
        tick();

        // 6: asynchronous reset mid-LOAD_D
        begin_txn(32'h55667788, 32'h99AABBCC);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_valid", bus_valid, 1'b0);
        chk("t6_rdreq", rd_req, 1'b0);
        chk("t6_done", done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        begin_txn(32'h01020304, 32'h05060708);
        ticks(10);
        rsp(10'h246);
        rsp(10'h000);
        expect_done("t6", 18'h00046, 1'b0);
        ticks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
